// File: rtl/exe_lsu_req_if.sv
`default_nettype none
// ============================================================================
// Module      : exe_lsu_req_if
// Description : Data-memory request/response bus between the execute-stage
//               load/store unit (master) and data memory (slave).
//               master : drives mem_req, mem_wr, mem_addr, mem_wstrb, mem_wdata
//                        and samples mem_addr_ok, mem_data_ok, mem_rdata.
//               slave  : the mirror image.
// Revision    : 1.0 - initial release
// ============================================================================
interface exe_lsu_req_if #(
    parameter int DATA_W = 32
);
    logic                  mem_req;
    logic                  mem_wr;
    logic [31:0]           mem_addr;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_addr_ok;
    logic                  mem_data_ok;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output mem_req,
        output mem_wr,
        output mem_addr,
        output mem_wstrb,
        output mem_wdata,
        input  mem_addr_ok,
        input  mem_data_ok,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_wr,
        input  mem_addr,
        input  mem_wstrb,
        input  mem_wdata,
        output mem_addr_ok,
        output mem_data_ok,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/exe_lsu_req.sv
`default_nettype none
// ============================================================================
// Module      : exe_lsu_req
// Description : Execute-stage load/store request unit. Checks alignment,
//               issues one memory request at a time, tracks up to OUTST
//               outstanding transactions in a metadata FIFO and turns memory
//               read data into aligned, sign/zero-extended load results.
// Ports       : clk, reset (async, active-low)
//               req_*      : request from execute (valid/ready handshake)
//               flush      : kill all in-flight work (responses suppressed)
//               ale        : alignment / illegal-size error on current request
//               mem        : data-memory bus (exe_lsu_req_if.master)
//               rsp_*      : one-cycle response pulse with tag and data
//               busy       : request pending or transactions outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module exe_lsu_req #(
    parameter int DATA_W = 32,
    parameter int OUTST  = 2,
    parameter int TAG_W  = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [1:0]          req_size,
    input  logic                req_sext,
    input  logic [31:0]         req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [TAG_W-1:0]    req_tag,
    input  logic                flush,
    output logic                ale,
    exe_lsu_req_if.master       mem,
    output logic                rsp_valid,
    output logic                rsp_wr,
    output logic [TAG_W-1:0]    rsp_tag,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                busy
);
    localparam int c_nbytes   = DATA_W / 8;
    localparam int c_off_w    = $clog2(c_nbytes);
    localparam int c_ptr_w    = (OUTST > 1) ? $clog2(OUTST) : 1;
    localparam int c_cnt_w    = $clog2(OUTST + 1);
    localparam bit c_no_dword = (DATA_W == 32);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [c_off_w-1:0]  w_off;
    logic [2:0]          w_off3;
    logic [2:0]          w_align_mask;
    logic [c_nbytes-1:0] w_strb_base;
    logic [DATA_W-1:0]   w_lane_mask;
    logic                w_accept;

    assign w_off  = req_addr[c_off_w-1:0];
    assign w_off3 = 3'(w_off);

    always_comb begin
        w_align_mask = 3'b000;
        w_strb_base  = '0;
        case (req_size)
            2'd0: begin w_align_mask = 3'b000; w_strb_base = c_nbytes'(8'h01); end
            2'd1: begin w_align_mask = 3'b001; w_strb_base = c_nbytes'(8'h03); end
            2'd2: begin w_align_mask = 3'b011; w_strb_base = c_nbytes'(8'h0F); end
            default: begin w_align_mask = 3'b111; w_strb_base = c_nbytes'(8'hFF); end
        endcase
    end

    // Byte-lane mask of the unshifted store data, one byte per strobe bit.
    always_comb begin
        w_lane_mask = '0;
        for (int b = 0; b < c_nbytes; b++) begin
            w_lane_mask[8*b +: 8] = {8{w_strb_base[b]}};
        end
    end

    assign ale = req_valid & ((|(w_off3 & w_align_mask)) |
                              ((req_size == 2'd3) & c_no_dword));

    // ------------------------------------------------------------------
    // Pending memory request (one at a time)
    // ------------------------------------------------------------------
    logic                r_mem_req;
    logic                r_mem_wr;
    logic [31:0]         r_mem_addr;
    logic [c_nbytes-1:0] r_mem_wstrb;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [c_off_w-1:0]  r_pend_off;
    logic [1:0]          r_pend_size;
    logic                r_pend_sext;
    logic [TAG_W-1:0]    r_pend_tag;
    logic                r_pend_disc;
    logic [c_cnt_w-1:0]  r_count;

    assign req_ready = ~r_mem_req & (r_count < c_cnt_w'(OUTST)) & ~flush;
    assign w_accept  = req_valid & req_ready & ~ale;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_req   <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wstrb <= '0;
            r_mem_wdata <= '0;
            r_pend_off  <= '0;
            r_pend_size <= '0;
            r_pend_sext <= 1'b0;
            r_pend_tag  <= '0;
            r_pend_disc <= 1'b0;
        end else begin
            // req_ready excludes both a pending request and flush, so an
            // accept never overlaps the hold or discard paths below.
            if (w_accept) begin
                r_mem_req   <= 1'b1;
                r_mem_wr    <= req_wr;
                r_mem_addr  <= req_addr;
                r_mem_wstrb <= req_wr ? (w_strb_base << w_off) : '0;
                r_mem_wdata <= (req_wdata & w_lane_mask) << {w_off, 3'b000};
                r_pend_off  <= w_off;
                r_pend_size <= req_size;
                r_pend_sext <= req_sext;
                r_pend_tag  <= req_tag;
                r_pend_disc <= 1'b0;
            end else if (r_mem_req && mem.mem_addr_ok) begin
                r_mem_req   <= 1'b0;
            end
            // A request already on the bus cannot be withdrawn; mark it
            // so its eventual response is dropped.
            if (r_mem_req && flush) begin
                r_pend_disc <= 1'b1;
            end
        end
    end

    assign mem.mem_req   = r_mem_req;
    assign mem.mem_wr    = r_mem_wr;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wstrb = r_mem_wstrb;
    assign mem.mem_wdata = r_mem_wdata;

    // ------------------------------------------------------------------
    // Outstanding-transaction metadata FIFO
    // ------------------------------------------------------------------
    logic [c_off_w-1:0] r_fifo_off  [OUTST];
    logic [1:0]         r_fifo_size [OUTST];
    logic               r_fifo_sext [OUTST];
    logic               r_fifo_wr   [OUTST];
    logic [TAG_W-1:0]   r_fifo_tag  [OUTST];
    logic               r_fifo_disc [OUTST];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic               w_push;
    logic               w_pop;

    assign w_push = r_mem_req & mem.mem_addr_ok;
    // A data_ok with nothing outstanding is a stray and is ignored.
    assign w_pop  = mem.mem_data_ok & (r_count != '0);

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_w'(OUTST - 1)) ? '0 : p + c_ptr_w'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < OUTST; i++) begin
                r_fifo_off[i]  <= '0;
                r_fifo_size[i] <= '0;
                r_fifo_sext[i] <= 1'b0;
                r_fifo_wr[i]   <= 1'b0;
                r_fifo_tag[i]  <= '0;
                r_fifo_disc[i] <= 1'b0;
            end
        end else begin
            if (flush) begin
                for (int i = 0; i < OUTST; i++) begin
                    r_fifo_disc[i] <= 1'b1;
                end
            end
            if (w_push) begin
                r_fifo_off[r_wr_ptr]  <= r_pend_off;
                r_fifo_size[r_wr_ptr] <= r_pend_size;
                r_fifo_sext[r_wr_ptr] <= r_pend_sext;
                r_fifo_wr[r_wr_ptr]   <= r_mem_wr;
                r_fifo_tag[r_wr_ptr]  <= r_pend_tag;
                r_fifo_disc[r_wr_ptr] <= r_pend_disc | flush;
                r_wr_ptr              <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Load data alignment and extension
    // ------------------------------------------------------------------
    logic [c_off_w-1:0] w_rd_off;
    logic [DATA_W-1:0]  w_shift;
    logic [DATA_W-1:0]  w_mask;
    logic               w_sign;
    logic [DATA_W-1:0]  w_load;

    assign w_rd_off = r_fifo_off[r_rd_ptr];
    assign w_shift  = mem.mem_rdata >> {w_rd_off, 3'b000};

    always_comb begin
        w_mask = '1;
        w_sign = 1'b0;
        case (r_fifo_size[r_rd_ptr])
            2'd0:    begin w_mask = DATA_W'(8'hFF);         w_sign = w_shift[7];  end
            2'd1:    begin w_mask = DATA_W'(16'hFFFF);      w_sign = w_shift[15]; end
            2'd2:    begin w_mask = DATA_W'(32'hFFFF_FFFF); w_sign = w_shift[31]; end
            default: begin w_mask = '1;                     w_sign = w_shift[DATA_W-1]; end
        endcase
    end

    assign w_load = (w_shift & w_mask) |
                    ((r_fifo_sext[r_rd_ptr] & w_sign) ? ~w_mask : '0);

    // ------------------------------------------------------------------
    // Response register
    // ------------------------------------------------------------------
    logic               r_rsp_valid;
    logic               r_rsp_wr;
    logic [TAG_W-1:0]   r_rsp_tag;
    logic [DATA_W-1:0]  r_rsp_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_wr    <= 1'b0;
            r_rsp_tag   <= '0;
            r_rsp_data  <= '0;
        end else begin
            // A flush in the pop cycle also kills the entry being popped.
            r_rsp_valid <= w_pop & ~(r_fifo_disc[r_rd_ptr] | flush);
            if (w_pop) begin
                r_rsp_wr   <= r_fifo_wr[r_rd_ptr];
                r_rsp_tag  <= r_fifo_tag[r_rd_ptr];
                r_rsp_data <= r_fifo_wr[r_rd_ptr] ? '0 : w_load;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_wr    = r_rsp_wr;
    assign rsp_tag   = r_rsp_tag;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_mem_req | (r_count != '0);

endmodule
`default_nettype wire
